spi_slave_fifo: RTL and testbench
=================================

SPI_SLAVE_FIFO -- requirements
Module: spi_slave_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: word length in bits, 4..32.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: entries per TX and per RX FIFO, power of 2, >=2.
REQ-003 SHALL have parameter MSB_FIRST, default 1: 1 = MSB shifted first, 0 = LSB first.
REQ-004 SHALL have port clk  input  1: system clock, all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1: reset, asynchronous, active-low.
REQ-006 SHALL have port cpol  input  1: SCLK idle level, runtime mode select.
REQ-007 SHALL have port cpha  input  1: 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-008 SHALL have ports sclk, cs_n, mosi  input  1 each: asynchronous SPI pins; cs_n active-low.
REQ-009 SHALL have port miso  output  1: serial data to master.
REQ-010 SHALL have ports tx_data  input  DATA_WIDTH, tx_valid  input  1, tx_ready  output  1: TX FIFO write handshake.
REQ-011 SHALL have ports rx_data  output  DATA_WIDTH, rx_valid  output  1, rx_ready  input  1: RX FIFO read handshake.
REQ-012 SHALL have ports rx_overrun, tx_underrun  output  1 each: single-clk error pulses.
REQ-013 SHALL have port busy  output  1: high while synchronised cs_n is low.

Function
REQ-014 SHALL synchronise sclk, cs_n, mosi through 2 flip-flops, then edge-detect against a third registered copy.
REQ-015 SHALL latch cpol/cpha on the synchronised cs_n falling edge; changes while busy SHALL be ignored.
REQ-016 Leading edge = sclk leaving the cpol level; trailing edge = sclk returning to it; sample edge = leading if cpha=0 else trailing; shift edge = the other.
REQ-017 On cs_n falling: bit counter := 0; shift-out register loaded from TX FIFO head (pop) if non-empty, else all-zeros with tx_underrun pulsed 1 clk.
REQ-018 cpha=0: first bit SHALL be on miso within 1 clk of the synchronised cs_n falling edge; cpha=1: first bit driven on first shift edge.
REQ-019 Each sample edge SHALL shift synchronised mosi into the RX shift register (MSB_FIRST order) and increment the bit counter.
REQ-020 Each shift edge SHALL advance miso to the next bit, except the first shift edge when cpha=1, which presents bit 0 of the word.
REQ-021 On the DATA_WIDTH-th sample edge: counter wraps to 0; word pushed to RX FIFO; next TX word loaded (pop or zeros+tx_underrun) for the following shift edge.
REQ-022 Push with RX FIFO full SHALL drop the new word, keep FIFO contents, pulse rx_overrun 1 clk.
REQ-023 cs_n rising mid-word SHALL discard the partial RX word (no push), reset counter; the already-popped TX word is lost.
REQ-024 miso SHALL be 0 while cs_n (synchronised) is high.
REQ-025 FIFOs: tx_ready = !tx_full; rx_valid = !rx_empty; rx_data = RX head (first-word fall-through); transfer when valid&&ready.
REQ-026 Simultaneous user write and SPI pop on TX, or SPI push and user read on RX, SHALL both succeed, including at full/empty; push to an empty RX FIFO with simultaneous read SHALL not lose data.
REQ-027 Pointers SHALL be log2(FIFO_DEPTH)+1 bits with wrap bit; full when addresses equal and wrap bits differ.
REQ-028 rx_valid SHALL rise 1 clk after the internal detection of the last sample edge.

Reset
REQ-029 rst_n low SHALL asynchronously clear: FIFOs empty (tx_ready=1, rx_valid=0, rx_data=0), miso=0, busy=0, rx_overrun=0, tx_underrun=0, counter=0, shift registers 0, latched mode = cpol 0/cpha 0, synchronisers to 1 for cs_n, 0 for sclk/mosi.
REQ-030 Reset mid-transfer SHALL abort the word; after release the block SHALL wait for a fresh cs_n falling edge before sampling.

Verification
REQ-031 Mode 0, DATA_WIDTH=8, MSB_FIRST=1: TX preloaded 0xA5, master sends 0x3C -> miso bits 1,0,1,0,0,1,0,1; rx_data=0x3C, rx_valid=1.
REQ-032 All four cpol/cpha modes, back-to-back 3 words under one cs_n, TX 0x11,0x22,0x33 -> master receives 0x11,0x22,0x33; RX FIFO holds 3 master words in order.
REQ-033 TX FIFO empty at cs_n fall -> tx_underrun one pulse, miso all 0 for the word.
REQ-034 FIFO_DEPTH=4, 5 words received, rx_ready=0 -> first 4 retained, rx_overrun one pulse on word 5.
REQ-035 cs_n raised after 5 bits -> no RX push, next cs_n cycle receives a clean full word.
REQ-036 rst_n asserted after bit 3 -> all outputs at reset values immediately; following transfer correct.

Source files
------------

// File: rtl/spi_slave_fifo.sv
// SPI slave with TX and RX word FIFOs. The SPI pins are oversampled by clk; all four
// CPOL/CPHA modes are supported, and the mode is latched at each chip-select assertion.
module spi_slave_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int MSB_FIRST  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic                  sclk,
  input  logic                  cs_n,
  input  logic                  mosi,
  output logic                  miso,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  rx_overrun,
  output logic                  tx_underrun,
  output logic                  busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [AW:0]   PTR_ONE  = (AW+1)'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);

  logic r_sclk_s1, r_sclk_s2, r_sclk_s3;
  logic r_cs_s1, r_cs_s2, r_cs_s3;
  logic r_mosi_s1, r_mosi_s2;
  logic [2:0] r_settle;

  logic                  r_active;
  logic                  r_cpol;
  logic                  r_cpha;
  logic [CW-1:0]         r_bit_cnt;
  logic [DATA_WIDTH-1:0] r_rx_sh;
  logic [DATA_WIDTH-1:0] r_tx_sh;
  logic                  r_miso;
  logic                  r_tx_underrun;
  logic                  r_rx_overrun;

  logic [DATA_WIDTH-1:0] r_tx_mem [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] r_rx_mem [FIFO_DEPTH];
  logic [AW:0]           r_tx_wr, r_tx_rd, r_rx_wr, r_rx_rd;

  logic w_sclk_rise, w_sclk_fall, w_cs_fall, w_cs_rise, w_live;
  logic w_lead, w_trail, w_sample, w_shift, w_word_done, w_tx_load;
  logic w_tx_empty, w_tx_full, w_tx_push, w_tx_pop;
  logic w_rx_empty, w_rx_full, w_rx_push, w_rx_pop, w_rx_drop;
  logic [DATA_WIDTH-1:0] w_tx_word, w_rx_word, w_sh_next, w_ld_next;
  logic w_sh_head, w_ld_head;

  // Two-flop synchronisers plus a third copy for edge detection. r_settle masks the
  // reset values of the chain so a cs_n held low across reset is not taken as a new frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk_s1 <= 1'b0;
      r_sclk_s2 <= 1'b0;
      r_sclk_s3 <= 1'b0;
      r_cs_s1   <= 1'b1;
      r_cs_s2   <= 1'b1;
      r_cs_s3   <= 1'b1;
      r_mosi_s1 <= 1'b0;
      r_mosi_s2 <= 1'b0;
      r_settle  <= 3'b000;
    end else begin
      r_sclk_s1 <= sclk;
      r_sclk_s2 <= r_sclk_s1;
      r_sclk_s3 <= r_sclk_s2;
      r_cs_s1   <= cs_n;
      r_cs_s2   <= r_cs_s1;
      r_cs_s3   <= r_cs_s2;
      r_mosi_s1 <= mosi;
      r_mosi_s2 <= r_mosi_s1;
      r_settle  <= {r_settle[1:0], 1'b1};
    end
  end

  assign w_sclk_rise = r_sclk_s2 & ~r_sclk_s3;
  assign w_sclk_fall = ~r_sclk_s2 & r_sclk_s3;
  assign w_cs_fall   = r_settle[2] & r_cs_s3 & ~r_cs_s2;
  assign w_cs_rise   = r_cs_s2 & ~r_cs_s3;
  assign w_live      = r_active & ~r_cs_s2;

  assign w_lead      = r_cpol ? w_sclk_fall : w_sclk_rise;
  assign w_trail     = r_cpol ? w_sclk_rise : w_sclk_fall;
  assign w_sample    = w_live & (r_cpha ? w_trail : w_lead);
  assign w_shift     = w_live & (r_cpha ? w_lead : w_trail);
  assign w_word_done = w_sample & (r_bit_cnt == CNT_LAST);
  assign w_tx_load   = w_cs_fall | w_word_done;

  // Both FIFOs use valid/ready: a word moves on any clk edge where valid && ready are high.
  assign w_tx_empty = (r_tx_wr == r_tx_rd);
  assign w_tx_full  = (r_tx_wr[AW] != r_tx_rd[AW]) && (r_tx_wr[AW-1:0] == r_tx_rd[AW-1:0]);
  assign w_tx_push  = tx_valid & ~w_tx_full;
  assign w_tx_pop   = w_tx_load & ~w_tx_empty;
  assign w_tx_word  = w_tx_empty ? '0 : r_tx_mem[r_tx_rd[AW-1:0]];

  assign w_rx_empty = (r_rx_wr == r_rx_rd);
  assign w_rx_full  = (r_rx_wr[AW] != r_rx_rd[AW]) && (r_rx_wr[AW-1:0] == r_rx_rd[AW-1:0]);
  assign w_rx_pop   = rx_ready & ~w_rx_empty;
  assign w_rx_push  = w_word_done & (~w_rx_full | w_rx_pop);
  assign w_rx_drop  = w_word_done & w_rx_full & ~w_rx_pop;

  always_comb begin
    w_rx_word = '0;
    w_sh_head = 1'b0;
    w_sh_next = '0;
    w_ld_head = 1'b0;
    w_ld_next = '0;
    if (MSB_FIRST != 0) begin
      w_rx_word = {r_rx_sh[DATA_WIDTH-2:0], r_mosi_s2};
      w_sh_head = r_tx_sh[DATA_WIDTH-1];
      w_sh_next = {r_tx_sh[DATA_WIDTH-2:0], 1'b0};
      w_ld_head = w_tx_word[DATA_WIDTH-1];
      w_ld_next = {w_tx_word[DATA_WIDTH-2:0], 1'b0};
    end else begin
      w_rx_word = {r_mosi_s2, r_rx_sh[DATA_WIDTH-1:1]};
      w_sh_head = r_tx_sh[0];
      w_sh_next = {1'b0, r_tx_sh[DATA_WIDTH-1:1]};
      w_ld_head = w_tx_word[0];
      w_ld_next = {1'b0, w_tx_word[DATA_WIDTH-1:1]};
    end
  end

  // With cpha=0 the first bit must be on miso before the first edge, so it is presented
  // straight from the load; with cpha=1 the first shift edge presents it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active  <= 1'b0;
      r_cpol    <= 1'b0;
      r_cpha    <= 1'b0;
      r_bit_cnt <= '0;
      r_rx_sh   <= '0;
      r_tx_sh   <= '0;
      r_miso    <= 1'b0;
    end else if (w_cs_rise) begin
      r_active  <= 1'b0;
      r_bit_cnt <= '0;
      r_rx_sh   <= '0;
      r_tx_sh   <= '0;
      r_miso    <= 1'b0;
    end else if (w_cs_fall) begin
      r_active  <= 1'b1;
      r_cpol    <= cpol;
      r_cpha    <= cpha;
      r_bit_cnt <= '0;
      r_rx_sh   <= '0;
      if (cpha) begin
        r_tx_sh <= w_tx_word;
        r_miso  <= 1'b0;
      end else begin
        r_tx_sh <= w_ld_next;
        r_miso  <= w_ld_head;
      end
    end else begin
      if (w_sample) begin
        r_rx_sh <= w_rx_word;
        if (w_word_done) begin
          r_bit_cnt <= '0;
          r_tx_sh   <= w_tx_word;
        end else begin
          r_bit_cnt <= r_bit_cnt + CNT_ONE;
        end
      end
      if (w_shift) begin
        r_miso  <= w_sh_head;
        r_tx_sh <= w_sh_next;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_underrun <= 1'b0;
      r_rx_overrun  <= 1'b0;
    end else begin
      r_tx_underrun <= w_tx_load & w_tx_empty;
      r_rx_overrun  <= w_rx_drop;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_wr <= '0;
      r_tx_rd <= '0;
      r_rx_wr <= '0;
      r_rx_rd <= '0;
    end else begin
      if (w_tx_push) r_tx_wr <= r_tx_wr + PTR_ONE;
      if (w_tx_pop)  r_tx_rd <= r_tx_rd + PTR_ONE;
      if (w_rx_push) r_rx_wr <= r_rx_wr + PTR_ONE;
      if (w_rx_pop)  r_rx_rd <= r_rx_rd + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wr[AW-1:0]] <= tx_data;
    if (w_rx_push) r_rx_mem[r_rx_wr[AW-1:0]] <= w_rx_word;
  end

  assign tx_ready    = ~w_tx_full;
  assign rx_valid    = ~w_rx_empty;
  assign rx_data     = w_rx_empty ? '0 : r_rx_mem[r_rx_rd[AW-1:0]];
  assign miso        = r_miso & ~r_cs_s2;
  assign busy        = ~r_cs_s2;
  assign tx_underrun = r_tx_underrun;
  assign rx_overrun  = r_rx_overrun;

endmodule

// File: tb/tb_spi_slave_fifo.sv
// Directed bench for spi_slave_fifo: a bit-banged SPI master drives the pins, and an
// expected-word queue checks words leaving the RX FIFO.
module tb_spi_slave_fifo;
  localparam int DW   = 8;
  localparam int HALF = 80;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cpol = 1'b0;
  logic          cpha = 1'b0;
  logic          sclk = 1'b0;
  logic          cs_n = 1'b1;
  logic          mosi = 1'b0;
  logic          miso;
  logic [DW-1:0] tx_data = '0;
  logic          tx_valid = 1'b0;
  logic          tx_ready;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          rx_ready = 1'b0;
  logic          rx_overrun;
  logic          tx_underrun;
  logic          busy;

  int n_vec = 0;
  int n_err = 0;
  int n_unr = 0;
  int n_ovr = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_tx_q[$];

  always #5 clk = ~clk;

  spi_slave_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(4), .MSB_FIRST(1)) dut (
    .clk(clk), .rst_n(rst_n), .cpol(cpol), .cpha(cpha), .sclk(sclk), .cs_n(cs_n),
    .mosi(mosi), .miso(miso), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_overrun(rx_overrun),
    .tx_underrun(tx_underrun), .busy(busy)
  );

  // Pulse counters: each count is the number of clk cycles the flag was high.
  always @(negedge clk) begin
    if (tx_underrun) n_unr++;
    if (rx_overrun)  n_ovr++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_tx(input logic [DW-1:0] d);
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    check("tx_ready", {31'b0, tx_ready}, 32'd1);
    exp_tx_q.push_back(d);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic set_mode(input logic p, input logic h);
    cpol = p;
    cpha = h;
    sclk = p;
    #100;
  endtask

  task automatic cs_open();
    cs_n = 1'b0;
    #150;
    check("busy", {31'b0, busy}, 32'd1);
  endtask

  task automatic cs_close();
    #HALF;
    cs_n = 1'b1;
    #200;
    check("busy_idle", {31'b0, busy}, 32'd0);
    check("miso_idle", {31'b0, miso}, 32'd0);
  endtask

  task automatic spi_word(input logic [DW-1:0] mo, input int nbits, output logic [DW-1:0] mi);
    mi = '0;
    for (int i = 0; i < nbits; i++) begin
      if (!cpha) begin
        mosi = mo[DW-1-i];
        #HALF;
        sclk = ~cpol;
        mi[DW-1-i] = miso;
        #HALF;
        sclk = cpol;
      end else begin
        sclk = ~cpol;
        mosi = mo[DW-1-i];
        #HALF;
        sclk = cpol;
        mi[DW-1-i] = miso;
        #HALF;
      end
    end
  endtask

  task automatic drain_rx(input int n);
    logic [DW-1:0] e;
    for (int k = 0; k < n; k++) begin
      int t;
      t = 0;
      @(negedge clk);
      while (!rx_valid && t < 50) begin
        @(negedge clk);
        t++;
      end
      check("rx_valid", {31'b0, rx_valid}, 32'd1);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      check("rx_data", {24'b0, rx_data}, {24'b0, e});
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
    end
  endtask

  initial begin
    logic [DW-1:0] mi;
    logic [DW-1:0] mo;
    int u0;
    int o0;

    repeat (3) @(negedge clk);
    check("rst_tx_ready", {31'b0, tx_ready}, 32'd1);
    check("rst_rx_valid", {31'b0, rx_valid}, 32'd0);
    check("rst_rx_data", {24'b0, rx_data}, 32'd0);
    check("rst_miso", {31'b0, miso}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_flags", {30'b0, rx_overrun, tx_underrun}, 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Mode 0 single word: miso must carry A5 MSB first while the master sends 3C.
    set_mode(1'b0, 1'b0);
    push_tx(8'hA5);
    exp_q.push_back(8'h3C);
    cs_open();
    spi_word(8'h3C, 8, mi);
    check("m0_miso", {24'b0, mi}, {24'b0, exp_tx_q.pop_front()});
    cs_close();
    drain_rx(1);

    // All four modes, three back-to-back words per frame.
    for (int m = 0; m < 4; m++) begin
      set_mode(m[1], m[0]);
      push_tx(8'h11);
      push_tx(8'h22);
      push_tx(8'h33);
      cs_open();
      for (int w = 0; w < 3; w++) begin
        mo = 8'($urandom_range(0, 255));
        exp_q.push_back(mo);
        spi_word(mo, 8, mi);
        check("mode_miso", {24'b0, mi}, {24'b0, exp_tx_q.pop_front()});
      end
      cs_close();
      drain_rx(3);
    end

    // Empty TX FIFO at frame start: one underrun pulse, zeros on miso.
    set_mode(1'b0, 1'b0);
    u0 = n_unr;
    cs_open();
    check("unr_pulse", n_unr - u0, 32'd1);
    mo = 8'($urandom_range(0, 255));
    exp_q.push_back(mo);
    spi_word(mo, 8, mi);
    check("unr_miso", {24'b0, mi}, 32'd0);
    cs_close();
    drain_rx(1);

    // Five words into a four-deep RX FIFO with no reader: fifth is dropped.
    o0 = n_ovr;
    cs_open();
    for (int w = 0; w < 5; w++) begin
      mo = 8'($urandom_range(0, 255));
      if (w < 4) exp_q.push_back(mo);
      spi_word(mo, 8, mi);
      if (w == 3) check("ovr_none_yet", n_ovr - o0, 32'd0);
    end
    cs_close();
    check("ovr_pulse", n_ovr - o0, 32'd1);
    drain_rx(4);
    @(negedge clk);
    check("ovr_drained", {31'b0, rx_valid}, 32'd0);

    // Frame aborted after five bits: nothing pushed, next frame is clean.
    cs_open();
    spi_word(8'($urandom_range(0, 255)), 5, mi);
    cs_close();
    check("part_nopush", {31'b0, rx_valid}, 32'd0);
    push_tx(8'h5A);
    mo = 8'($urandom_range(0, 255));
    exp_q.push_back(mo);
    cs_open();
    spi_word(mo, 8, mi);
    check("part_next_miso", {24'b0, mi}, {24'b0, exp_tx_q.pop_front()});
    cs_close();
    drain_rx(1);

    // Reset three bits into the second word, with one word sitting in the RX FIFO.
    push_tx(8'h4B);
    cs_open();
    spi_word(8'($urandom_range(0, 255)), 8, mi);
    check("pre_rst_miso", {24'b0, mi}, {24'b0, exp_tx_q.pop_front()});
    spi_word(8'($urandom_range(0, 255)), 3, mi);
    check("pre_rst_rxv", {31'b0, rx_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_rx_valid", {31'b0, rx_valid}, 32'd0);
    check("mid_rst_rx_data", {24'b0, rx_data}, 32'd0);
    check("mid_rst_tx_ready", {31'b0, tx_ready}, 32'd1);
    check("mid_rst_miso", {31'b0, miso}, 32'd0);
    check("mid_rst_busy", {31'b0, busy}, 32'd0);
    check("mid_rst_flags", {30'b0, rx_overrun, tx_underrun}, 32'd0);
    #50;
    rst_n = 1'b1;
    @(negedge clk);
    repeat (5) @(negedge clk);

    // cs_n still low from before reset: no frame may start without a fresh falling edge.
    spi_word(8'hFF, 8, mi);
    #HALF;
    check("no_fresh_fall_rx", {31'b0, rx_valid}, 32'd0);
    check("no_fresh_fall_miso", {24'b0, mi}, 32'd0);
    cs_n = 1'b1;
    #200;

    push_tx(8'h96);
    mo = 8'($urandom_range(0, 255));
    exp_q.push_back(mo);
    cs_open();
    spi_word(mo, 8, mi);
    check("post_rst_miso", {24'b0, mi}, {24'b0, exp_tx_q.pop_front()});
    cs_close();
    drain_rx(1);
    check("sb_empty", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
